// File: rtl/aes_frame_tx_pkg.sv
// Shared AES host-side definitions: key sizes, process select, frame length and
// the transmitter state encoding.
package aes_pkg;

    localparam int AES_KEY128_BYTES = 16;
    localparam int AES_KEY192_BYTES = 24;
    localparam int AES_KEY256_BYTES = 32;

    localparam logic PROC_DECRYPT = 1'b0;
    localparam logic PROC_ENCRYPT = 1'b1;

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_KSIZE,
        TX_KEY,
        TX_PROC,
        TX_DONE,
        TX_GAP,
        TX_REJECT
    } tx_state_t;

    // Bytes for which 'we' is high: start + 16 data + ksize + K key + proc.
    function automatic logic [5:0] frame_bytes(input logic [5:0] kbytes);
        return 6'd19 + kbytes;
    endfunction

    function automatic logic key_size_legal(input logic [5:0] kbytes);
        return (kbytes == 6'(AES_KEY128_BYTES)) ||
               (kbytes == 6'(AES_KEY192_BYTES)) ||
               (kbytes == 6'(AES_KEY256_BYTES));
    endfunction

endpackage

// File: rtl/aes_frame_tx_if.sv
// Job request handshake plus the byte-load pins towards the AES core.
interface aes_frame_tx_if;

    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_data;
    logic [255:0] req_key;
    logic [5:0]   req_keybytes;
    logic         req_encrypt;
    logic         we;
    logic [7:0]   Indata;
    logic         done;
    logic         err;

    modport master (
        output req_valid, req_data, req_key, req_keybytes, req_encrypt,
        input  req_ready, we, Indata, done, err
    );

    modport slave (
        input  req_valid, req_data, req_key, req_keybytes, req_encrypt,
        output req_ready, we, Indata, done, err
    );

endinterface

// File: rtl/aes_frame_tx_byte_serializer.sv
// Parallel-load shift register that presents its most significant byte and
// moves the next byte up on every shift.
module byte_serializer #(
    parameter int WIDTH = 384
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic [7:0]       top_byte
);

    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_data;
        end else if (shift) begin
            shreg_q <= {shreg_q[WIDTH-9:0], 8'h00};
        end
    end

    assign top_byte = shreg_q[WIDTH-1 -: 8];

endmodule

// File: rtl/aes_frame_tx.sv
// Accepts one AES job and streams it to the core as start, data, key-size,
// key and process bytes, with registered outputs throughout.
module aes_frame_tx #(
    parameter int GAP_CYCLES = 0
) (
    input  logic           clk,
    input  logic           reset,
    aes_frame_tx_if.slave  bus
);

    import aes_pkg::*;

    localparam logic [5:0] GAP_LAST = (GAP_CYCLES > 0) ? 6'(GAP_CYCLES - 1) : 6'd0;

    tx_state_t  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] kbytes_q, kbytes_d;
    logic       enc_q, enc_d;
    logic       we_q, we_d;
    logic [7:0] indata_q, indata_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       ready_q, ready_d;

    logic       accept;
    logic       ser_shift;
    logic [7:0] ser_top;

    // ready_q is only ever high while state_q is IDLE, so it alone gates acceptance.
    assign accept    = bus.req_valid && ready_q;
    assign ser_shift = (state_d == TX_DATA) || (state_d == TX_KEY);

    byte_serializer #(.WIDTH(384)) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data ({bus.req_data, bus.req_key}),
        .shift     (ser_shift),
        .top_byte  (ser_top)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        kbytes_d = kbytes_q;
        enc_d    = enc_q;
        unique case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    kbytes_d = bus.req_keybytes;
                    enc_d    = bus.req_encrypt;
                    state_d  = key_size_legal(bus.req_keybytes) ? TX_START : TX_REJECT;
                end
            end
            TX_START: state_d = TX_DATA;
            TX_DATA: begin
                if (cnt_q == 6'd15) state_d = TX_KSIZE;
                else                cnt_d   = cnt_q + 6'd1;
            end
            TX_KSIZE: state_d = TX_KEY;
            TX_KEY: begin
                if (cnt_q == kbytes_q - 6'd1) state_d = TX_PROC;
                else                          cnt_d   = cnt_q + 6'd1;
            end
            TX_PROC: state_d = TX_DONE;
            TX_DONE: state_d = (GAP_CYCLES > 0) ? TX_GAP : TX_IDLE;
            TX_GAP: begin
                if (cnt_q == GAP_LAST) state_d = TX_IDLE;
                else                   cnt_d   = cnt_q + 6'd1;
            end
            TX_REJECT: state_d = TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one is a plain register.
    always_comb begin
        we_d     = state_d inside {TX_START, TX_DATA, TX_KSIZE, TX_KEY, TX_PROC};
        done_d   = (state_d == TX_DONE);
        err_d    = (state_d == TX_REJECT);
        ready_d  = (state_d == TX_IDLE);
        indata_d = 8'h00;
        unique case (state_d)
            TX_DATA, TX_KEY: indata_d = ser_top;
            TX_KSIZE:        indata_d = {2'b00, kbytes_d};
            TX_PROC:         indata_d = {7'd0, enc_d};
            default:         indata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            kbytes_q <= '0;
            enc_q    <= 1'b0;
            we_q     <= 1'b0;
            indata_q <= 8'h00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kbytes_q <= kbytes_d;
            enc_q    <= enc_d;
            we_q     <= we_d;
            indata_q <= indata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.we        = we_q;
    assign bus.Indata    = indata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_aes_frame_tx.sv
// Directed bench for aes_frame_tx: FIPS-197 style frames, reject, mid-frame
// reset, input capture and inter-frame gap on a second instance.
module tb_aes_frame_tx;

    localparam logic [127:0] DATA_V    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_FIELD = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [407:0] S16 = 408'h00_00112233445566778899aabbccddeeff_10_000102030405060708090a0b0c0d0e0f_01;
    localparam logic [407:0] S32 = 408'h00_00112233445566778899aabbccddeeff_20_000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f_00;
    localparam logic [407:0] S24 = 408'h00_00112233445566778899aabbccddeeff_18_000102030405060708090a0b0c0d0e0f1011121314151617_01;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    aes_frame_tx_if bus0();
    aes_frame_tx_if bus1();

    aes_frame_tx #(.GAP_CYCLES(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    aes_frame_tx #(.GAP_CYCLES(3)) u_dut_gap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string name, input logic [5:0] k, input logic enc,
                             input logic [407:0] stream, input int nbytes, input logic scramble);
        logic [7:0] exp_b;
        chk({name, " ready_before"}, 32'(bus0.req_ready), 32'd1);
        bus0.req_valid    = 1'b1;
        bus0.req_data     = DATA_V;
        bus0.req_key      = KEY_FIELD;
        bus0.req_keybytes = k;
        bus0.req_encrypt  = enc;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        if (scramble) begin
            bus0.req_data     = ~DATA_V;
            bus0.req_key      = ~KEY_FIELD;
            bus0.req_keybytes = 6'd32;
            bus0.req_encrypt  = ~enc;
        end
        for (int i = 0; i < nbytes; i++) begin
            exp_b = 8'(stream >> (8 * (nbytes - 1 - i)));
            chk($sformatf("%s byte%0d", name, i), 32'(bus0.Indata), 32'(exp_b));
            chk($sformatf("%s we%0d", name, i), 32'(bus0.we), 32'd1);
            chk($sformatf("%s ready_busy%0d", name, i), 32'(bus0.req_ready), 32'd0);
            @(negedge clk);
        end
        chk({name, " done_pulse"}, 32'(bus0.done), 32'd1);
        chk({name, " we_low"}, 32'(bus0.we), 32'd0);
        chk({name, " indata_idle"}, 32'(bus0.Indata), 32'd0);
        @(negedge clk);
        chk({name, " done_clear"}, 32'(bus0.done), 32'd0);
        chk({name, " ready_after"}, 32'(bus0.req_ready), 32'd1);
        $display("frame %s k=%0d bytes=%0d checked", name, k, nbytes);
    endtask

    task automatic run_len(input logic val, output int n, output logic rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        while (bus1.we === val && n < 200) begin
            rdy_seen = rdy_seen | bus1.req_ready;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   n0, n1, n2, n3;
        logic r1, r2, r3;
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_data = '0; bus0.req_key = '0;
        bus0.req_keybytes = '0; bus0.req_encrypt = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_data = '0; bus1.req_key = '0;
        bus1.req_keybytes = '0; bus1.req_encrypt = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst we", 32'(bus0.we), 32'd0);
        chk("rst indata", 32'(bus0.Indata), 32'd0);
        chk("rst done", 32'(bus0.done), 32'd0);
        chk("rst err", 32'(bus0.err), 32'd0);
        chk("rst ready", 32'(bus0.req_ready), 32'd0);
        chk("rst ready_gap", 32'(bus1.req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst ready", 32'(bus0.req_ready), 32'd1);
        chk("post_rst ready_gap", 32'(bus1.req_ready), 32'd1);
        $display("reset released");

        run_frame("c1_k16_enc", 6'd16, 1'b1, S16, 35, 1'b0);
        run_frame("k32_dec", 6'd32, 1'b0, S32, 51, 1'b0);

        // Illegal key size: accepted, err for one cycle, no frame.
        bus0.req_valid = 1'b1;
        bus0.req_keybytes = 6'd20;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("reject err", 32'(bus0.err), 32'd1);
        chk("reject we", 32'(bus0.we), 32'd0);
        chk("reject ready_n1", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        chk("reject err_clear", 32'(bus0.err), 32'd0);
        chk("reject ready_n2", 32'(bus0.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reject we_idle%0d", i), 32'(bus0.we), 32'd0);
            @(negedge clk);
        end
        $display("reject k=20 checked");

        // Reset while data byte 7 is on the bus.
        bus0.req_valid = 1'b1;
        bus0.req_data = DATA_V;
        bus0.req_key = KEY_FIELD;
        bus0.req_keybytes = 6'd16;
        bus0.req_encrypt = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst byte7", 32'(bus0.Indata), 32'h77);
        #2 reset = 1'b0;
        #1;
        chk("midrst we", 32'(bus0.we), 32'd0);
        chk("midrst indata", 32'(bus0.Indata), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst no_done%0d", i), 32'(bus0.done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst done_after", 32'(bus0.done), 32'd0);
        $display("mid-frame reset checked");

        run_frame("k24_after_rst", 6'd24, 1'b1, S24, 43, 1'b0);
        run_frame("capture_hold", 6'd16, 1'b1, S16, 35, 1'b1);

        // GAP_CYCLES=3 instance with req_valid held high across two frames.
        bus1.req_valid = 1'b1;
        bus1.req_data = DATA_V;
        bus1.req_key = KEY_FIELD;
        bus1.req_keybytes = 6'd16;
        bus1.req_encrypt = 1'b1;
        run_len(1'b0, n0, r1);
        chk("gap lead_low", 32'(n0), 32'd1);
        run_len(1'b1, n1, r1);
        chk("gap frame1_len", 32'(n1), 32'd35);
        chk("gap frame1_ready", 32'(r1), 32'd0);
        run_len(1'b0, n2, r2);
        // DONE + 3 gap cycles + the IDLE cycle in which the request is accepted.
        chk("gap low_cycles", 32'(n2), 32'd5);
        bus1.req_valid = 1'b0;
        run_len(1'b1, n3, r3);
        chk("gap frame2_len", 32'(n3), 32'd35);
        chk("gap frame2_ready", 32'(r3), 32'd0);
        $display("gap frames high=%0d low=%0d high=%0d", n1, n2, n3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
